// File: rtl/sram_march_bist.sv
// March-test initiator for a small flip-flop SRAM.
// On an accepted start it runs four march elements over every address:
//   M0 up   : w(P)
//   M1 up   : r(P),  w(~P)
//   M2 down : r(~P), w(P)
//   M3 down : r(P)
// Each read is compared on the clock edge that ends the read cycle.
// The block reports the result: mismatch count (saturating), the first
// failing address/expected/got triple, and a pass flag with a done pulse.
// While busy it is the only driver of the SRAM port.
module sram_march_bist #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ERR_W  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic [ADDR_W-1:0] mem_add,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_add,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    typedef enum logic [2:0] {
        IDLE,
        M0_W,
        M1_R,
        M1_W,
        M2_R,
        M2_W,
        M3_R,
        FIN
    } state_t;

    // End-of-element is detected by comparing against the explicit end
    // address, so the counter never relies on wrapping.
    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   pat_reg, pat_next;
    logic [ERR_W-1:0]    err_reg, err_next;
    logic                pass_reg, pass_next;
    logic [ADDR_W-1:0]   fail_add_reg, fail_add_next;
    logic [DATA_W-1:0]   fail_exp_reg, fail_exp_next;
    logic [DATA_W-1:0]   fail_got_reg, fail_got_next;

    logic                is_read;
    logic                is_write;
    logic [DATA_W-1:0]   exp_data;
    logic [DATA_W-1:0]   diff_bits;
    logic                mismatch;

    // Decode the current step: which cycles read/write, and the data
    // expected on the bus (P or ~P depending on the march element).
    always_comb begin
        is_read  = (state_reg == M1_R) || (state_reg == M2_R) || (state_reg == M3_R);
        is_write = (state_reg == M0_W) || (state_reg == M1_W) || (state_reg == M2_W);
        if ((state_reg == M1_W) || (state_reg == M2_R)) begin
            exp_data = ~pat_reg;
        end else begin
            exp_data = pat_reg;
        end
    end

    // Per-bit difference between the SRAM read data and the expected word.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_diff
            assign diff_bits[gi] = mem_rd[gi] ^ exp_data[gi];
        end
    endgenerate

    assign mismatch = is_read && (|diff_bits);

    // SRAM port and status outputs are decoded straight from the state
    // register, so an asynchronous reset drops mem_we immediately.
    always_comb begin
        mem_we   = is_write;
        mem_wd   = is_write ? exp_data : '0;
        mem_add  = ((state_reg == IDLE) || (state_reg == FIN)) ? '0 : addr_reg;
        busy     = (state_reg != IDLE) && (state_reg != FIN);
        done     = (state_reg == FIN);
        pass     = (state_reg == FIN) ? (err_reg == '0) : pass_reg;
        err_cnt  = err_reg;
        fail_add = fail_add_reg;
        fail_exp = fail_exp_reg;
        fail_got = fail_got_reg;
    end

    // Next-state, address sequencing and result bookkeeping.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        pat_next      = pat_reg;
        err_next      = err_reg;
        pass_next     = pass_reg;
        fail_add_next = fail_add_reg;
        fail_exp_next = fail_exp_reg;
        fail_got_next = fail_got_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = M0_W;
                    addr_next     = ADDR_FIRST;
                    pat_next      = pattern;
                    err_next      = '0;
                    pass_next     = 1'b0;
                    fail_add_next = '0;
                    fail_exp_next = '0;
                    fail_got_next = '0;
                end
            end
            M0_W: begin
                if (addr_reg == ADDR_LAST) begin
                    state_next = M1_R;
                    addr_next  = ADDR_FIRST;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                end
            end
            M1_R: state_next = M1_W;
            M1_W: begin
                if (addr_reg == ADDR_LAST) begin
                    state_next = M2_R;
                    addr_next  = ADDR_LAST;
                end else begin
                    state_next = M1_R;
                    addr_next  = addr_reg + 1'b1;
                end
            end
            M2_R: state_next = M2_W;
            M2_W: begin
                if (addr_reg == ADDR_FIRST) begin
                    state_next = M3_R;
                    addr_next  = ADDR_LAST;
                end else begin
                    state_next = M2_R;
                    addr_next  = addr_reg - 1'b1;
                end
            end
            M3_R: begin
                if (addr_reg == ADDR_FIRST) begin
                    state_next = FIN;
                end else begin
                    addr_next  = addr_reg - 1'b1;
                end
            end
            FIN: begin
                state_next = IDLE;
                pass_next  = (err_reg == '0);
            end
            default: state_next = IDLE;
        endcase

        // A read that disagrees bumps the saturating counter; only the
        // first one of a run (counter still zero) records the details.
        if (mismatch) begin
            if (err_reg != ERR_MAX) begin
                err_next = err_reg + ERR_W'(1);
            end
            if (err_reg == '0) begin
                fail_add_next = addr_reg;
                fail_exp_next = exp_data;
                fail_got_next = mem_rd;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            pat_reg      <= '0;
            err_reg      <= '0;
            pass_reg     <= 1'b0;
            fail_add_reg <= '0;
            fail_exp_reg <= '0;
            fail_got_reg <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            pat_reg      <= pat_next;
            err_reg      <= err_next;
            pass_reg     <= pass_next;
            fail_add_reg <= fail_add_next;
            fail_exp_reg <= fail_exp_next;
            fail_got_reg <= fail_got_next;
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: bench-owned SRAM with injectable faults,
// a march-level reference model producing one expected record per cycle,
// and a single negedge compare process. Directed scenarios add literal
// expectations; a randomized phase varies pattern, fault and stray starts.
module tb_sram_march_bist;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] pattern;
    logic [2:0]  mem_add;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  err_cnt;
    logic [2:0]  fail_add;
    logic [31:0] fail_exp;
    logic [31:0] fail_got;

    sram_march_bist #(
        .ADDR_W(3), .DATA_W(32), .DEPTH(8), .ERR_W(4)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .pattern(pattern),
        .mem_add(mem_add), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_add(fail_add), .fail_exp(fail_exp), .fail_got(fail_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] ex);
        tests_run++;
        if (got !== ex) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, ex, $time);
        end
    endfunction

    // ---------------- SRAM model with faults ----------------
    // fault_kind: 0 none, 1 one bit of one address stuck, 2 read always 0
    int          fault_kind = 0;
    int          fault_addr = 0;
    int          fault_bit  = 0;
    logic        fault_val  = 1'b0;
    logic [31:0] sram [8];

    function automatic logic [31:0] filt(input int a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (fault_kind == 1 && a == fault_addr) r[fault_bit] = fault_val;
        return r;
    endfunction

    assign mem_rd = (fault_kind == 2) ? 32'h0 : sram[mem_add];

    always @(posedge clk) begin
        if (mem_we) sram[mem_add] <= filt(int'(mem_add), mem_wd);
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        we;
        logic [2:0]  add;
        logic [31:0] wd;
        logic [3:0]  err;
        logic        pass;
        logic [2:0]  fadd;
        logic [31:0] fexp;
        logic [31:0] fgot;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        idle_rec;
    logic [31:0] mdl [8];
    int          m_err;
    int          m_fa;
    logic [31:0] m_fe, m_fg;

    task automatic m_op(input bit w, input int a, input logic [31:0] d);
        rec_t        r;
        logic [31:0] got;
        r      = '0;
        r.busy = 1'b1;
        r.we   = w;
        r.add  = a[2:0];
        r.wd   = w ? d : 32'h0;
        r.err  = m_err[3:0];
        r.fadd = m_fa[2:0];
        r.fexp = m_fe;
        r.fgot = m_fg;
        exp_q.push_back(r);
        if (w) begin
            mdl[a] = filt(a, d);
        end else begin
            got = (fault_kind == 2) ? 32'h0 : mdl[a];
            if (got !== d) begin
                if (m_err == 0) begin
                    m_fa = a; m_fe = d; m_fg = got;
                end
                if (m_err != 15) m_err++;
            end
        end
    endtask

    task automatic build_run(input logic [31:0] p);
        rec_t r;
        m_err = 0; m_fa = 0; m_fe = 0; m_fg = 0;
        for (int a = 0; a < 8; a++) m_op(1, a, p);
        for (int a = 0; a < 8; a++) begin m_op(0, a, p);  m_op(1, a, ~p); end
        for (int a = 7; a >= 0; a--) begin m_op(0, a, ~p); m_op(1, a, p); end
        for (int a = 7; a >= 0; a--) m_op(0, a, p);
        r      = '0;
        r.done = 1'b1;
        r.err  = m_err[3:0];
        r.pass = (m_err == 0);
        r.fadd = m_fa[2:0];
        r.fexp = m_fe;
        r.fgot = m_fg;
        exp_q.push_back(r);
        idle_rec      = r;
        idle_rec.done = 1'b0;
    endtask

    // ---------------- monitors ----------------
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [34:0] wlog[$];

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (mem_we) wlog.push_back({mem_add, mem_wd});
    end

    // Single compare process: every cycle against the model's record.
    always @(negedge clk) begin
        rec_t r;
        if (exp_q.size() > 0) r = exp_q.pop_front();
        else r = idle_rec;
        chk("busy",     busy,     r.busy);
        chk("done",     done,     r.done);
        chk("mem_we",   mem_we,   r.we);
        chk("mem_add",  mem_add,  r.add);
        chk("mem_wd",   mem_wd,   r.wd);
        chk("err_cnt",  err_cnt,  r.err);
        chk("pass",     pass,     r.pass);
        chk("fail_add", fail_add, r.fadd);
        chk("fail_exp", fail_exp, r.fexp);
        chk("fail_got", fail_got, r.fgot);
    end

    // ---------------- stimulus tasks ----------------
    task automatic run_start(input logic [31:0] p);
        @(posedge clk); #1;
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        build_run(p);
        busy_cnt = 0;
        wlog.delete();
        #1;
        start = 1'b0;
    endtask

    // Full run; optionally a stray start pulse during busy cycle spur (2..49).
    task automatic run_full(input logic [31:0] p, input int spur, input logic [31:0] sp);
        int d0;
        d0 = done_cnt;
        run_start(p);
        for (int k = 2; k <= 49; k++) begin
            @(posedge clk); #1;
            if (k == spur) begin
                pattern = sp;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulses", done_cnt, d0 + 1);
        chk("busy_cycles", busy_cnt, 48);
        $display("[TB] run P=%08h fault=%0d stray=%0d -> pass=%0d err=%0d fail_add=%0d",
                 p, fault_kind, spur, pass, err_cnt, fail_add);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        resetn   = 1'b0;
        start    = 1'b0;
        pattern  = 32'h0;
        idle_rec = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: fault-free, AAAAAAAA
        fault_kind = 0;
        run_full(32'hAAAAAAAA, 0, 32'h0);
        chk("s1_pass", pass, 1);
        chk("s1_err", err_cnt, 0);
        chk("s1_wlog_size", wlog.size(), 24);
        chk("s1_w0", wlog[0], {3'd0, 32'hAAAAAAAA});
        chk("s1_w7", wlog[7], {3'd7, 32'hAAAAAAAA});
        chk("s1_w8", wlog[8], {3'd0, 32'h55555555});
        chk("s1_w15", wlog[15], {3'd7, 32'h55555555});
        chk("s1_w16", wlog[16], {3'd7, 32'hAAAAAAAA});
        chk("s1_w23", wlog[23], {3'd0, 32'hAAAAAAAA});

        // 2: bit0 of addr 5 stuck at 0
        fault_kind = 1; fault_addr = 5; fault_bit = 0; fault_val = 1'b0;
        run_full(32'h00000001, 0, 32'h0);
        chk("s2_pass", pass, 0);
        chk("s2_err", err_cnt, 2);
        chk("s2_fail_add", fail_add, 5);
        chk("s2_fail_exp", fail_exp, 32'h00000001);
        chk("s2_fail_got", fail_got, 32'h00000000);

        // 6: back-to-back fault-free run clears previous result
        fault_kind = 0;
        run_full(32'h3C3C3C3C, 0, 32'h0);
        chk("s6_pass", pass, 1);
        chk("s6_err", err_cnt, 0);
        chk("s6_fail_add", fail_add, 0);
        chk("s6_fail_exp", fail_exp, 0);
        chk("s6_fail_got", fail_got, 0);

        // 3: read always 0 -> saturation
        fault_kind = 2;
        run_full(32'hFFFFFFFF, 0, 32'h0);
        chk("s3_pass", pass, 0);
        chk("s3_err", err_cnt, 15);
        chk("s3_fail_add", fail_add, 0);
        chk("s3_fail_exp", fail_exp, 32'hFFFFFFFF);
        chk("s3_fail_got", fail_got, 0);

        // 4: stray start at busy cycle 10 is ignored
        fault_kind = 0;
        run_full(32'h0F0F0F0F, 10, 32'h12345678);
        chk("s4_last_write", wlog[23], {3'd0, 32'h0F0F0F0F});
        d0 = done_cnt;
        repeat (12) @(posedge clk);
        #1;
        chk("s4_no_rerun_done", done_cnt, d0);
        chk("s4_no_rerun_busy", busy_cnt, 48);

        // 5: reset mid-run during busy cycle 20 (M1_W at address 5)
        fault_kind = 2;
        run_start(32'hFFFFFFFF);
        repeat (19) @(posedge clk);
        #2;
        chk("s5_pre_we", mem_we, 1);
        chk("s5_pre_add", mem_add, 5);
        chk("s5_pre_err", err_cnt, 6);
        exp_q.delete();
        idle_rec = '0;
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        chk("s5_rst_we", mem_we, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_err", err_cnt, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("s5_no_done", done_cnt, d0);
        fault_kind = 0;
        run_full(32'hC0FFEE11, 0, 32'h0);
        chk("s5_after_pass", pass, 1);

        // Randomized runs
        for (int it = 0; it < 10; it++) begin
            int spur;
            fault_kind = $urandom_range(0, 2);
            fault_addr = $urandom_range(0, 7);
            fault_bit  = $urandom_range(0, 31);
            fault_val  = 1'($urandom_range(0, 1));
            spur = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 49);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_full($urandom, spur, $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
